fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Sequencing controller for the RV32I program counter register (ports clk, rst, pc_jmp, pc_in, pc_out).
- Decides each cycle whether the PC free-runs (+4), holds, or loads a new target.
- Arbitrates between boot, instruction-memory wait, decode stall, branch/jump redirect and trap.
- Drives the instruction-memory request and the fetch-valid strobe to decode.

Parameters:
RESET_VEC, 32'h0000_0000, PC loaded on the first cycle after reset
TRAP_VEC, 32'h0000_0100, PC loaded on a trap, fetch timeout or misaligned redirect
TIMEOUT, 16, maximum consecutive cycles the block waits for imem_ready before faulting (≥2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
pc_cur  in  32  current PC (pc_out of PC register)
pc_jmp  out  1  load strobe to PC register
pc_in  out  32  load value to PC register
imem_req  out  1  instruction fetch request
imem_addr  out  32  fetch address
imem_ready  in  1  memory returns instruction this cycle
stall  in  1  decode cannot accept an instruction
if_valid  out  1  fetched instruction valid for decode
if_pc  out  32  PC of instruction presented on if_valid
redir_valid  in  1  branch/jump taken
redir_target  in  32  branch/jump target
trap_req  in  1  exception/interrupt request
fetch_fault  out  1  one-cycle pulse on fetch timeout
misalign_err  out  1  one-cycle pulse on misaligned redirect target

Behaviour:
- Single clock domain; reset is synchronous and active-high. While rst=1:
  - state←BOOT, wait_cnt←0.
  - All outputs 0: pc_jmp, pc_in, imem_req, imem_addr, if_valid, if_pc, fetch_fault, misalign_err.
- pc_jmp, pc_in, imem_req, imem_addr are combinational from state and inputs, so the PC register updates on the same edge. if_pc is registered in HOLD, combinational (=pc_cur) in FETCH.
- Hold PC = pc_jmp=1, pc_in=pc_cur. Advance = pc_jmp=0 (PC increments by 4).
- BOOT (one cycle after rst falls): pc_jmp=1, pc_in=RESET_VEC, imem_req=0, if_valid=0 → FETCH. Redirects/traps are ignored in BOOT.
- FETCH: imem_req=1, imem_addr=pc_cur.
  - imem_ready=1, stall=0: if_valid=1, if_pc=pc_cur, advance; wait_cnt←0; stay FETCH.
  - imem_ready=1, stall=1: if_valid=1, latch if_pc←pc_cur, hold PC; wait_cnt←0 → HOLD.
  - imem_ready=0: if_valid=0, hold PC, wait_cnt+1.
  - imem_ready=0 with wait_cnt==TIMEOUT-1: fetch_fault=1, pc_jmp=1, pc_in=TRAP_VEC, wait_cnt←0, stay FETCH.
- HOLD: imem_req=0, if_valid=1, if_pc=latched value.
  - stall=1: hold PC.
  - stall=0: advance → FETCH.
- Redirect priority in FETCH/HOLD, overriding all of the above: trap_req > redir_valid > normal.
  - trap_req=1: pc_jmp=1, pc_in=TRAP_VEC.
  - redir_valid=1, redir_target[1:0]==0: pc_jmp=1, pc_in=redir_target.
  - redir_valid=1, redir_target[1:0]!=0: misalign_err=1, pc_jmp=1, pc_in=TRAP_VEC.
  - Any redirect/trap: if_valid=0 that cycle (flush), imem_req=0, wait_cnt←0, next state FETCH. Any in-flight imem_ready that cycle is discarded.
- Trap coinciding with timeout: trap wins, fetch_fault=0. Redirect coinciding with timeout: redirect wins, fetch_fault=0.
- Reset mid-wait or mid-HOLD: all state discarded, BOOT sequence repeats.
- wait_cnt width = clog2(TIMEOUT); it never exceeds TIMEOUT-1.
- PC wrap (0xFFFF_FFFC+4→0) is handled by the PC register; the controller does not intervene.

Test Plan:
- Boot: rst=1 two cycles, release, imem_ready=1 → cycle 1 pc_jmp=1/pc_in=0; then if_valid each cycle with if_pc 0x0,0x4,0x8,0xC.
- Memory wait: imem_ready=0 for 3 cycles at pc 0x8 → pc_cur stays 0x8, if_valid=0; ready → if_valid, if_pc=0x8, next pc 0xC.
- Stall: stall=1 for 2 cycles as 0x10 returns → if_valid held with if_pc=0x10, pc_cur=0x10, imem_req=0; stall=0 → pc 0x14, back to FETCH.
- Redirect: redir_valid=1, target 0x1000 at pc 0x20 → same cycle if_valid=0, next pc_cur=0x1000, fetch 0x1000,0x1004. Target 0x1002 → misalign_err pulse, pc_cur=0x100.
- Priority: trap_req and redir_valid (0x2000) together → pc_cur=0x100, no misalign_err.
- Timeout: TIMEOUT=16, imem_ready=0 forever from pc 0x40 → fetch_fault pulse on the 16th wait cycle, pc_cur=0x100, wait_cnt restarts. Assert rst during this wait → BOOT then pc_cur=0x0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Fetch sequencing controller for the RV32I PC register: chooses advance, hold
// or load each cycle and drives the instruction-memory request and decode strobe.
module fetch_ctrl #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0100,
  parameter int          TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  output logic        pc_jmp,
  output logic [31:0] pc_in,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_pc,
  input  logic        redir_valid,
  input  logic [31:0] redir_target,
  input  logic        trap_req,
  output logic        fetch_fault,
  output logic        misalign_err
);

  localparam int CW = (TIMEOUT <= 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] wait_cnt_reg, wait_cnt_next;
  logic [31:0]   hold_pc_reg, hold_pc_next;
  logic          flush;

  assign flush = trap_req | redir_valid;

  always_comb begin
    pc_jmp        = 1'b0;
    pc_in         = 32'h0;
    imem_req      = 1'b0;
    imem_addr     = 32'h0;
    if_valid      = 1'b0;
    if_pc         = 32'h0;
    fetch_fault   = 1'b0;
    misalign_err  = 1'b0;
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    hold_pc_next  = hold_pc_reg;

    if (!rst) begin
      case (state_reg)
        BOOT: begin
          pc_jmp        = 1'b1;
          pc_in         = RESET_VEC;
          wait_cnt_next = '0;
          state_next    = FETCH;
        end

        FETCH, HOLD: begin
          if (state_reg == FETCH) begin
            imem_addr = pc_cur;
            if_pc     = pc_cur;
          end else begin
            if_pc     = hold_pc_reg;
          end

          if (flush) begin
            // Trap beats redirect; a misaligned target is converted into a trap.
            pc_jmp        = 1'b1;
            wait_cnt_next = '0;
            state_next    = FETCH;
            if (trap_req) begin
              pc_in = TRAP_VEC;
            end else if (redir_target[1:0] != 2'b00) begin
              pc_in        = TRAP_VEC;
              misalign_err = 1'b1;
            end else begin
              pc_in = redir_target;
            end
          end else if (state_reg == HOLD) begin
            if_valid = 1'b1;
            if (stall) begin
              pc_jmp = 1'b1;
              pc_in  = pc_cur;
            end else begin
              state_next = FETCH;
            end
          end else begin
            imem_req = 1'b1;
            if (imem_ready) begin
              if_valid      = 1'b1;
              wait_cnt_next = '0;
              if (stall) begin
                pc_jmp       = 1'b1;
                pc_in        = pc_cur;
                hold_pc_next = pc_cur;
                state_next   = HOLD;
              end
            end else begin
              pc_jmp = 1'b1;
              if (wait_cnt_reg == WAIT_LAST) begin
                fetch_fault   = 1'b1;
                pc_in         = TRAP_VEC;
                wait_cnt_next = '0;
              end else begin
                pc_in         = pc_cur;
                wait_cnt_next = wait_cnt_reg + CW'(1);
              end
            end
          end
        end

        default: state_next = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= BOOT;
      wait_cnt_reg <= '0;
      hold_pc_reg  <= 32'h0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      hold_pc_reg  <= hold_pc_next;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: a PC register plus a behavioural model of the fetch
// rules, compared every cycle under directed and random stimulus.
module tb_fetch_ctrl;
  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;
  localparam int          TIMEOUT   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_cur;
  logic        pc_jmp;
  logic [31:0] pc_in;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        stall = 1'b0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_target = 32'h0;
  logic        trap_req = 1'b0;
  logic        fetch_fault;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  fetch_ctrl #(.RESET_VEC(RESET_VEC), .TRAP_VEC(TRAP_VEC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .pc_cur(pc_cur), .pc_jmp(pc_jmp), .pc_in(pc_in),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .stall(stall), .if_valid(if_valid), .if_pc(if_pc),
    .redir_valid(redir_valid), .redir_target(redir_target), .trap_req(trap_req),
    .fetch_fault(fetch_fault), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  // The PC register the controller steers.
  logic [31:0] pc_reg = 32'h0;
  always_ff @(posedge clk) begin
    if (rst)         pc_reg <= 32'h0;
    else if (pc_jmp) pc_reg <= pc_in;
    else             pc_reg <= pc_reg + 32'd4;
  end
  assign pc_cur = pc_reg;

  // Model: boot pending, an optional held instruction, and a count of consecutive misses.
  bit          m_boot = 1'b1, n_boot = 1'b1;
  bit          m_held = 1'b0, n_held = 1'b0;
  logic [31:0] m_held_pc = 32'h0, n_held_pc = 32'h0;
  int          m_waits = 0, n_waits = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    bit          e_jmp, e_req, e_valid, e_fault, e_mis;
    logic [31:0] e_pcin, e_ifpc;
    e_jmp = 0; e_req = 0; e_valid = 0; e_fault = 0; e_mis = 0;
    e_pcin = 32'h0; e_ifpc = 32'h0;
    n_boot = m_boot; n_held = m_held; n_held_pc = m_held_pc; n_waits = m_waits;
    if (rst) begin
      n_boot = 1; n_held = 0; n_waits = 0;
    end else if (m_boot) begin
      e_jmp = 1; e_pcin = RESET_VEC; n_boot = 0; n_waits = 0;
    end else if (trap_req || redir_valid) begin
      e_jmp = 1;
      if (trap_req) e_pcin = TRAP_VEC;
      else if (redir_target % 4 != 0) begin e_pcin = TRAP_VEC; e_mis = 1; end
      else e_pcin = redir_target;
      n_held = 0; n_waits = 0;
    end else if (m_held) begin
      e_valid = 1; e_ifpc = m_held_pc;
      e_jmp = stall; e_pcin = pc_cur;
      if (!stall) n_held = 0;
    end else begin
      e_req = 1;
      if (imem_ready) begin
        e_valid = 1; e_ifpc = pc_cur; n_waits = 0;
        e_jmp = stall; e_pcin = pc_cur;
        if (stall) begin n_held = 1; n_held_pc = pc_cur; end
      end else begin
        e_jmp = 1;
        n_waits = m_waits + 1;
        if (n_waits == TIMEOUT) begin
          e_fault = 1; e_pcin = TRAP_VEC; n_waits = 0;
        end else begin
          e_pcin = pc_cur;
        end
      end
    end
    chk("pc_jmp", {31'h0, pc_jmp}, {31'h0, e_jmp});
    if (e_jmp || rst) chk("pc_in", pc_in, e_pcin);
    chk("imem_req", {31'h0, imem_req}, {31'h0, e_req});
    if (e_req || rst) chk("imem_addr", imem_addr, rst ? 32'h0 : pc_cur);
    chk("if_valid", {31'h0, if_valid}, {31'h0, e_valid});
    if (e_valid || rst) chk("if_pc", if_pc, e_ifpc);
    chk("fetch_fault", {31'h0, fetch_fault}, {31'h0, e_fault});
    chk("misalign_err", {31'h0, misalign_err}, {31'h0, e_mis});
  endtask

  task automatic step(input logic r, input logic rdy, input logic st, input logic rv,
                      input logic [31:0] tgt, input logic tr);
    @(posedge clk);
    m_boot = n_boot; m_held = n_held; m_held_pc = n_held_pc; m_waits = n_waits;
    #1;
    rst = r; imem_ready = rdy; stall = st; redir_valid = rv; redir_target = tgt; trap_req = tr;
    @(negedge clk);
    $display("t=%0t rst=%b rdy=%b stall=%b redir=%b/%h trap=%b | pc=%h jmp=%b pc_in=%h req=%b valid=%b if_pc=%h ff=%b mis=%b",
             $time, r, rdy, st, rv, tgt, tr, pc_cur, pc_jmp, pc_in, imem_req, if_valid, if_pc,
             fetch_fault, misalign_err);
    model_check();
  endtask

  initial begin
    logic [31:0] tgt;
    bit          burst;

    // Boot
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    chk("rst_pc_jmp", {31'h0, pc_jmp}, 32'h0);
    chk("rst_if_valid", {31'h0, if_valid}, 32'h0);
    step(0, 1, 0, 0, 0, 0);
    chk("boot_jmp", {31'h0, pc_jmp}, 32'h1);
    chk("boot_pc_in", pc_in, 32'h0);
    step(0, 1, 0, 0, 0, 0);
    chk("boot_if_pc0", if_pc, 32'h0);
    step(0, 1, 0, 0, 0, 0);
    chk("boot_if_pc4", if_pc, 32'h4);

    // Memory wait at 0x8
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 0, 0);
      chk("wait_pc", pc_cur, 32'h8);
    end
    step(0, 1, 0, 0, 0, 0);
    chk("wait_if_pc", if_pc, 32'h8);
    step(0, 1, 0, 0, 0, 0);
    chk("after_wait_pc", pc_cur, 32'hC);

    // Stall as 0x10 returns
    step(0, 1, 1, 0, 0, 0);
    chk("stall_if_pc", if_pc, 32'h10);
    step(0, 0, 1, 0, 0, 0);
    chk("hold_pc", pc_cur, 32'h10);
    chk("hold_req", {31'h0, imem_req}, 32'h0);
    chk("hold_if_pc", if_pc, 32'h10);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("resume_pc", pc_cur, 32'h14);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);

    // Redirects
    step(0, 1, 0, 1, 32'h1000, 0);
    chk("redir_pc_at", pc_cur, 32'h20);
    chk("redir_flush", {31'h0, if_valid}, 32'h0);
    chk("redir_pc_in", pc_in, 32'h1000);
    step(0, 1, 0, 0, 0, 0);
    chk("redir_if_pc", if_pc, 32'h1000);
    step(0, 1, 0, 0, 0, 0);
    chk("redir_if_pc2", if_pc, 32'h1004);
    step(0, 1, 0, 1, 32'h1002, 0);
    chk("misalign_pulse", {31'h0, misalign_err}, 32'h1);
    step(0, 1, 0, 1, 32'h2000, 1);
    chk("misalign_trap_pc", pc_cur, 32'h100);
    chk("prio_pc_in", pc_in, 32'h100);
    chk("prio_no_mis", {31'h0, misalign_err}, 32'h0);
    step(0, 0, 0, 1, 32'h40, 0);

    // Timeout from 0x40
    for (int k = 1; k <= TIMEOUT; k++) begin
      step(0, 0, 0, 0, 0, 0);
      chk("to_pc", pc_cur, 32'h40);
      chk("to_fault", {31'h0, fetch_fault}, (k == TIMEOUT) ? 32'h1 : 32'h0);
    end
    chk("to_pc_in", pc_in, 32'h100);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, 0, 0, 0);
      chk("to_restart_pc", pc_cur, 32'h100);
    end
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("reboot_pc_in", pc_in, 32'h0);
    step(0, 0, 0, 0, 0, 0);
    chk("reboot_pc", pc_cur, 32'h0);

    // Trap, then redirect, coinciding with timeout (first miss already taken above)
    for (int k = 2; k < TIMEOUT; k++) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("trap_to_fault", {31'h0, fetch_fault}, 32'h0);
    for (int k = 1; k < TIMEOUT; k++) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h80, 0);
    chk("redir_to_fault", {31'h0, fetch_fault}, 32'h0);
    chk("redir_to_pc_in", pc_in, 32'h80);

    // Random traffic with periodic long memory outages
    for (int i = 0; i < 3000; i++) begin
      burst = ((i % 300) >= 200) && ((i % 300) < 225);
      tgt = $urandom;
      if ($urandom_range(3) != 0) tgt[1:0] = 2'b00;
      step($urandom_range(199) == 0,
           burst ? 1'b0 : ($urandom_range(9) < 7),
           $urandom_range(3) == 0,
           !burst && ($urandom_range(19) == 0),
           tgt,
           !burst && ($urandom_range(39) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
